// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready payload register with a 2-entry skid buffer and flush-to-bubble.
// Latency: 1 cycle in_data -> out_data when empty or draining; 1 payload/cycle with out_ready held high.
// Backpressure: in_ready is a decode of the occupancy flop (low only when the skid slot is full), never of out_ready.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake, in_data is the payload
//   out_valid/out_ready - downstream handshake, out_data is the payload (BUBBLE_VALUE when not valid)
//   flush               - discard every held payload and any payload offered this cycle
//   stall_cnt/flush_cnt - saturating perf counters, present only when PIPE_STAGE_PERF_EN is defined
module pipe_stage_skid #(
   parameter int                DATA_W       = 96,
   parameter logic [DATA_W-1:0] BUBBLE_VALUE = {DATA_W{1'b0}},
   parameter int                CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // Encoding chosen so bit 0 is main_v and bit 1 is skid_v.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } occ_t;

   occ_t              occ;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_d;
   logic              main_v;
   logic              skid_v;
   logic              acc;
   logic              drn;

   if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("pipe_stage_skid: DATA_W and CNT_W must be at least 1");
   end

   assign main_v    = (occ != EMPTY);
   assign skid_v    = (occ == TWO);
   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign out_data  = main_d;

   assign acc = in_valid && in_ready;
   assign drn = main_v && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ    <= EMPTY;
         main_d <= BUBBLE_VALUE;
         skid_d <= BUBBLE_VALUE;
      end else if (flush) begin
         // Flush wins over any accept or drain in the same cycle; a drain
         // still happened on the wire, the offered payload is simply lost.
         occ    <= EMPTY;
         main_d <= BUBBLE_VALUE;
         skid_d <= BUBBLE_VALUE;
      end else begin
         case (occ)
            EMPTY: begin
               if (acc) begin
                  occ    <= ONE;
                  main_d <= in_data;
               end
            end
            ONE: begin
               if (acc && drn) begin
                  main_d <= in_data;
               end else if (acc) begin
                  occ    <= TWO;
                  skid_d <= in_data;
               end else if (drn) begin
                  // Keep out_data at the bubble whenever nothing is valid.
                  occ    <= EMPTY;
                  main_d <= BUBBLE_VALUE;
               end
            end
            TWO: begin
               // in_ready is low here, so only a drain can move anything.
               if (drn) begin
                  occ    <= ONE;
                  main_d <= skid_d;
               end
            end
            default: begin
               occ    <= EMPTY;
               main_d <= BUBBLE_VALUE;
               skid_d <= BUBBLE_VALUE;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (main_v && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush && (main_v || skid_v) && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus random traffic against a queue-based reference.
// Latency: checks every cycle on the falling edge, one cycle after the stimulus edge.
// Backpressure: random out_ready and flush exercise stall, skid fill and flush-over-drain.
module tb_pipe_stage_skid;

   localparam int          DW  = 96;
   localparam int          CW  = 4;
   localparam logic [DW-1:0] BUB = 96'h13;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          flush;
`ifdef PIPE_STAGE_PERF_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
`endif

   pipe_stage_skid #(
      .DATA_W      (DW),
      .BUBBLE_VALUE(BUB),
      .CNT_W       (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .flush    (flush)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: the stage is a FIFO of depth 2 that is emptied by flush.
   logic [DW-1:0] mq[$];
   int            m_stall = 0;
   int            m_flush = 0;
   int            m_deliv = 0;
   int            dut_deliv = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", {95'b0, out_valid}, {95'b0, mq.size() > 0});
      chk("in_ready",  {95'b0, in_ready},  {95'b0, mq.size() < 2});
      chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : BUB);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", {92'b0, stall_cnt}, DW'(m_stall));
      chk("flush_cnt", {92'b0, flush_cnt}, DW'(m_flush));
`endif
   endtask

   // Called on a falling edge; applies inputs, advances one clock, checks on the next falling edge.
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
      logic m_acc;
      logic m_drn;
      in_valid  = v;
      in_data   = v ? d : 'x;
      out_ready = ordy;
      flush     = fl;
      m_acc = v && (mq.size() < 2);
      m_drn = (mq.size() > 0) && ordy;
      @(posedge clk);
      if (out_valid && out_ready) dut_deliv++;
      if (mq.size() > 0 && !ordy && m_stall < (1 << CW) - 1) m_stall++;
      if (fl && mq.size() > 0 && m_flush < (1 << CW) - 1) m_flush++;
      if (m_drn) m_deliv++;
      if (fl) begin
         mq.delete();
      end else begin
         if (m_drn) void'(mq.pop_front());
         if (m_acc) mq.push_back(d);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      mq.delete();
      m_stall = 0;
      m_flush = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("reset_out_valid", {95'b0, out_valid}, '0);
      chk("reset_in_ready",  {95'b0, in_ready},  {95'b0, 1'b1});
      chk("reset_out_data",  out_data, BUB);
      reset = 1'b0;
      @(negedge clk);

      // First payload one cycle after acceptance.
      cycle(1'b1, 96'hA, 1'b1, 1'b0);
      chk("first_payload", out_data, 96'hA);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Streaming 0x1..0x8 back to back.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, DW'(i), 1'b1, 1'b0);
         chk("stream_data", out_data, DW'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Stall: 0x2 goes to skid, 0x3 held upstream, then released in order.
      cycle(1'b1, 96'h1, 1'b1, 1'b0);
      cycle(1'b1, 96'h2, 1'b0, 1'b0);
      chk("stall_in_ready_low", {95'b0, in_ready}, '0);
      cycle(1'b1, 96'h3, 1'b0, 1'b0);
      chk("stall_hold_data", out_data, 96'h1);
      cycle(1'b1, 96'h3, 1'b1, 1'b0);
      chk("stall_rel_2", out_data, 96'h2);
      cycle(1'b1, 96'h3, 1'b1, 1'b0);
      chk("stall_rel_3", out_data, 96'h3);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Flush in TWO with a payload on the input.
      cycle(1'b1, 96'h5, 1'b0, 1'b0);
      cycle(1'b1, 96'h6, 1'b0, 1'b0);
      cycle(1'b1, 96'h7, 1'b0, 1'b1);
      chk("flush_out_valid", {95'b0, out_valid}, '0);
      chk("flush_out_data",  out_data, BUB);
      chk("flush_in_ready",  {95'b0, in_ready}, {95'b0, 1'b1});
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Flush coinciding with a drain still delivers the payload.
      cycle(1'b1, 96'h9, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("flush_drain_empty", {95'b0, out_valid}, '0);

      // Asynchronous reset mid-stream with two entries held.
      cycle(1'b1, 96'hB, 1'b0, 1'b0);
      cycle(1'b1, 96'hC, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", {95'b0, out_valid}, '0);
      chk("arst_in_ready",  {95'b0, in_ready},  {95'b0, 1'b1});
      chk("arst_out_data",  out_data, BUB);
      do_reset();
      cycle(1'b1, 96'hA, 1'b1, 1'b0);
      chk("post_rst_first", out_data, 96'hA);
      cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
      do_reset();
      cycle(1'b1, 96'h21, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      chk("perf_stall_sat", {92'b0, stall_cnt}, DW'(15));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("perf_flush_one", {92'b0, flush_cnt}, DW'(1));
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0,
               {$urandom(), $urandom(), $urandom()},
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 31) == 0);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      chk("delivered_count", DW'(dut_deliv), DW'(m_deliv));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
